uart_reg_bank_v2: RTL and testbench
===================================

Name: uart_reg_bank_v2

Overview:
- Parametrised successor to the UART register mapper. Decodes received UART command packets into per-channel PWM/DAC configuration registers.
- Adds double buffering: host writes go to shadow registers, and a commit command applies a channel mask atomically to the active registers.
- Adds an acknowledge/read-back response stream with checksum, plus error reporting.
- Sits between the UART packet receiver (upstream) and the pattern_pwm / pattern_ad9748 channel instances and UART transmitter (downstream).

Parameters:
NUM_CHANNELS, 4, number of channels; legal range 1..8.
PAT_WIDTH, 32, pattern register width; legal values 8, 16, 24, 32.

Ports:
clk_50M  in  1  system clock; all logic in this single domain.
rst  in  1  synchronous active-high reset.
func_reg  in  8  command code; valid only while pack_done=1.
pkt_data  in  88  payload; byte k at [8k+7:8k] = rev_data(k+1); byte0 = channel number.
pack_done  in  1  one-cycle packet-complete strobe.
hs_ctrl_sta_bus  out  8*NUM_CHANNELS  active HS control, channel i at [8i+7:8i].
duty_num_bus  out  8*NUM_CHANNELS  active duty count.
pulse_dessert_bus  out  16*NUM_CHANNELS  active pulse gap.
pulse_num_bus  out  8*NUM_CHANNELS  active pulse count.
pat_bus  out  PAT_WIDTH*NUM_CHANNELS  active pattern.
ls_ctrl_sta_bus  out  8*NUM_CHANNELS  active LS control.
pwm_en  out  NUM_CHANNELS  bit i = active hs_ctrl_sta[i][0].
cfg_update  out  NUM_CHANNELS  one-cycle pulse per channel committed.
tx_data  out  8  response byte.
tx_valid  out  1  response byte valid.
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready.
busy  out  1  high from command latch until last response byte accepted.
err_cnt  out  8  dropped/rejected command count; saturates at 0xFF.

Behaviour:
- Reset (rst=1 at a clk_50M edge): all shadow and active registers 0; all outputs 0; FSM enters IDLE. Reset mid-response aborts it immediately; tx_valid is 0 on the next cycle.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: pack_done=1 latches func_reg and pkt_data; busy=1 from the next cycle; go to EXEC.
- EXEC lasts one cycle and performs the decode. ch = byte0; bad_ch = ch >= NUM_CHANNELS.
  - 0x01: if !bad_ch, shadow[ch] gets ctrl=b1, duty=b2, dessert={b3,b4}, num=b5, PAT = low PAT_WIDTH bits of {b6,b7,b8,b9}.
  - 0x02: if !bad_ch, shadow ls_ctrl[ch] = b1.
  - 0x03 commit: byte0 is the channel mask (bits >= NUM_CHANNELS ignored). For every mask bit i, active[i] <= shadow[i] at the EXEC edge, and cfg_update[i]=1 for exactly that cycle, coincident with the new active values. Mask 0 is legal and is a no-op with OK status.
  - 0x04 read-back: reads active registers of channel ch (not shadow).
  - Any other code: status BAD_FUNC.
  - Status codes: 0x00 OK, 0x01 BAD_CH (no register written), 0x02 BAD_FUNC.
- RESP sequence for 0x01/0x02/0x03 and errors: 4 bytes: 0xA5, func, status, XOR of the three preceding bytes.
- RESP sequence for 0x04 with valid ch: 14 bytes: 0xA5, 0x04, ch, ctrl, duty, dessert[15:8], dessert[7:0], num, PAT zero-extended to 32 bits (MSB byte first, 4 bytes), ls_ctrl, XOR of bytes 0..12.
- 0x04 with bad ch uses the 4-byte form with status 0x01.
- tx handshake:
  - tx_valid rises the first cycle of RESP.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - The next byte is presented the cycle after acceptance; no bubbles are permitted beyond that.
  - After the last byte is accepted, tx_valid=0 and busy=0 in the same cycle, and the FSM returns to IDLE.
- pack_done while busy=1: command dropped, no register change, err_cnt+1. Commands answered with BAD_CH or BAD_FUNC also increment err_cnt. err_cnt saturates at 0xFF.
- Latency: pack_done at cycle N gives shadow/active update at edge N+2 and tx_valid=1 at cycle N+2.
- Active registers change only on commit; shadow writes never alter outputs.

Test Plan:
- Write then commit: 0x01 ch1 b1..b9 = 01,10,00,32,05,DE,AD,BE,EF, then 0x03 mask 0x02 -> pat_bus ch1 = 0xDEADBEEF, duty 0x10, dessert 0x0032, pwm_en=0010, cfg_update=0010 for one cycle; response A5 01 00 A4, then A5 03 00 A6.
- Shadow isolation: 0x01 ch0 without commit -> all active buses stay 0; 0x04 ch0 returns zeros in payload with correct XOR.
- Read-back with backpressure: after the first test, 0x04 ch1 with tx_ready toggling 1/0 -> 14 bytes A5 04 01 01 10 00 32 05 DE AD BE EF 00 plus XOR; every byte held while not ready.
- Errors: 0x01 ch=4 (NUM_CHANNELS=4) -> A5 01 01 A5, err_cnt=1, no write; func 0x7F -> A5 7F 02 D8, err_cnt=2.
- Overrun and reset: pack_done during a 14-byte response -> command ignored, err_cnt+1; assert rst mid-response -> tx_valid=0 and all buses 0 the next cycle.
- Parameter sweep: NUM_CHANNELS=8, PAT_WIDTH=16 -> commit mask 0xFF updates all 8 channels; PAT truncated to {b8,b9}; read-back PAT bytes 00 00 b8 b9.

Source files
------------

// File: rtl/uart_reg_bank_v2.sv
// -----------------------------------------------------------------------------
// uart_reg_bank_v2
//
// Decodes UART command packets into per-channel PWM/DAC configuration.
// Host writes land in shadow registers. A commit command copies a masked set
// of shadow channels into the active registers in a single edge, so a
// downstream channel never sees a half-written configuration. Every command
// is answered on a byte-wide response stream that ends in an XOR checksum.
//
// Parameters
//   NUM_CHANNELS  number of channels, 1..8
//   PAT_WIDTH     pattern register width, 8/16/24/32
//
// Ports
//   clk_50M            system clock (single domain)
//   rst                synchronous active-high reset
//   func_reg           command code, qualified by pack_done
//   pkt_data           payload, byte k at [8k+7:8k]; byte0 = channel / mask
//   pack_done          one-cycle packet-complete strobe
//   hs_ctrl_sta_bus    active HS control, channel i at [8i+7:8i]
//   duty_num_bus       active duty count
//   pulse_dessert_bus  active pulse gap (16 bits per channel)
//   pulse_num_bus      active pulse count
//   pat_bus            active pattern (PAT_WIDTH bits per channel)
//   ls_ctrl_sta_bus    active LS control
//   pwm_en             bit i = active HS control bit 0 of channel i
//   cfg_update         one-cycle pulse per channel on commit
//   tx_data/tx_valid   response byte stream
//   tx_ready           transmitter accepts on tx_valid & tx_ready
//   busy               command in flight (latched until last byte accepted)
//   err_cnt            dropped/rejected command count, saturating
// -----------------------------------------------------------------------------
module uart_reg_bank_v2 #(
  parameter int NUM_CHANNELS = 4,
  parameter int PAT_WIDTH    = 32
) (
  input  logic                              clk_50M,
  input  logic                              rst,
  input  logic [7:0]                        func_reg,
  input  logic [87:0]                       pkt_data,
  input  logic                              pack_done,
  output logic [8*NUM_CHANNELS-1:0]         hs_ctrl_sta_bus,
  output logic [8*NUM_CHANNELS-1:0]         duty_num_bus,
  output logic [16*NUM_CHANNELS-1:0]        pulse_dessert_bus,
  output logic [8*NUM_CHANNELS-1:0]         pulse_num_bus,
  output logic [PAT_WIDTH*NUM_CHANNELS-1:0] pat_bus,
  output logic [8*NUM_CHANNELS-1:0]         ls_ctrl_sta_bus,
  output logic [NUM_CHANNELS-1:0]           pwm_en,
  output logic [NUM_CHANNELS-1:0]           cfg_update,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic [7:0]                        err_cnt
);

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] FN_WRITE_HS = 8'h01;
  localparam logic [7:0] FN_WRITE_LS = 8'h02;
  localparam logic [7:0] FN_COMMIT   = 8'h03;
  localparam logic [7:0] FN_READ     = 8'h04;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CH   = 8'h01;
  localparam logic [7:0] ST_BAD_FUNC = 8'h02;
  localparam int         RESP_MAX    = 14;
  localparam logic [8:0] CH_LIMIT    = 9'(NUM_CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  typedef struct packed {
    logic [7:0]           ctrl;
    logic [7:0]           duty;
    logic [15:0]          dessert;
    logic [7:0]           num;
    logic [PAT_WIDTH-1:0] pat;
    logic [7:0]           ls_ctrl;
  } ch_cfg_t;

  state_t      state, state_nxt;
  ch_cfg_t     shadow [NUM_CHANNELS];
  ch_cfg_t     active [NUM_CHANNELS];
  logic [7:0]  cmd_func;
  logic [87:0] cmd_data;
  logic [7:0]  resp_buf [RESP_MAX];
  logic [3:0]  resp_len;
  logic [3:0]  resp_idx;

  // Decode of the latched command; only consumed while in S_EXEC.
  logic [7:0]  pb [11];
  logic [7:0]  ch;
  logic        bad_ch;
  logic [7:0]  status;
  logic [31:0] pat_full;
  logic [31:0] rd_pat;
  ch_cfg_t     new_cfg;
  ch_cfg_t     rd_cfg;
  logic [7:0]  rsp [RESP_MAX];
  logic [3:0]  rsp_len;
  logic [7:0]  rsp_xor;
  logic        drop;
  logic        exec_err;
  logic [8:0]  err_sum;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path can leave it holding its old value and infer a latch.
  always_comb begin
    for (int k = 0; k < 11; k++) pb[k] = cmd_data[8*k +: 8];
    ch       = pb[0];
    bad_ch   = {1'b0, ch} >= CH_LIMIT;
    pat_full = {pb[6], pb[7], pb[8], pb[9]};

    new_cfg         = '0;
    new_cfg.ctrl    = pb[1];
    new_cfg.duty    = pb[2];
    new_cfg.dessert = {pb[3], pb[4]};
    new_cfg.num     = pb[5];
    new_cfg.pat     = pat_full[PAT_WIDTH-1:0];

    // Read-back reports what the channels are actually running.
    rd_cfg = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch == 8'(i)) rd_cfg = active[i];
    end
    rd_pat = 32'(rd_cfg.pat);

    case (cmd_func)
      FN_WRITE_HS, FN_WRITE_LS, FN_READ: status = bad_ch ? ST_BAD_CH : ST_OK;
      FN_COMMIT:                         status = ST_OK;
      default:                           status = ST_BAD_FUNC;
    endcase

    for (int k = 0; k < RESP_MAX; k++) rsp[k] = '0;
    rsp[0] = SYNC_BYTE;
    if (cmd_func == FN_READ && !bad_ch) begin
      rsp[1]  = FN_READ;
      rsp[2]  = ch;
      rsp[3]  = rd_cfg.ctrl;
      rsp[4]  = rd_cfg.duty;
      rsp[5]  = rd_cfg.dessert[15:8];
      rsp[6]  = rd_cfg.dessert[7:0];
      rsp[7]  = rd_cfg.num;
      rsp[8]  = rd_pat[31:24];
      rsp[9]  = rd_pat[23:16];
      rsp[10] = rd_pat[15:8];
      rsp[11] = rd_pat[7:0];
      rsp[12] = rd_cfg.ls_ctrl;
      rsp_len = 4'd14;
    end else begin
      rsp[1]  = cmd_func;
      rsp[2]  = status;
      rsp_len = 4'd4;
    end

    // Unused tail bytes are zero, so one XOR over the first 13 slots serves
    // both response lengths.
    rsp_xor = '0;
    for (int k = 0; k < RESP_MAX - 1; k++) rsp_xor = rsp_xor ^ rsp[k];
    if (rsp_len == 4'd14) rsp[13] = rsp_xor;
    else                  rsp[3]  = rsp_xor;

    drop     = pack_done && (state != S_IDLE);
    exec_err = (state == S_EXEC) && (status != ST_OK);
    err_sum  = {1'b0, err_cnt} + 9'(drop) + 9'(exec_err);
  end

  // FSM: state register.
  always_ff @(posedge clk_50M) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state)
      S_IDLE: if (pack_done) state_nxt = S_EXEC;
      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = resp_buf[resp_idx];
        if (tx_ready && resp_idx == resp_len - 4'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command latch, register banks, response buffer, error count.
  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      // NOTE: the register banks are reset explicitly: the outputs must be 0
      // after reset and they are small flop arrays, not RAM macros.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      for (int k = 0; k < RESP_MAX; k++) resp_buf[k] <= '0;
      cmd_func   <= '0;
      cmd_data   <= '0;
      resp_len   <= '0;
      resp_idx   <= '0;
      cfg_update <= '0;
      err_cnt    <= '0;
    end else begin
      cfg_update <= '0;
      err_cnt    <= err_sum[8] ? 8'hFF : err_sum[7:0];

      if (state == S_IDLE && pack_done) begin
        cmd_func <= func_reg;
        cmd_data <= pkt_data;
      end

      if (state == S_EXEC) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (!bad_ch && ch == 8'(i)) begin
            if (cmd_func == FN_WRITE_HS) begin
              shadow[i].ctrl    <= new_cfg.ctrl;
              shadow[i].duty    <= new_cfg.duty;
              shadow[i].dessert <= new_cfg.dessert;
              shadow[i].num     <= new_cfg.num;
              shadow[i].pat     <= new_cfg.pat;
            end
            if (cmd_func == FN_WRITE_LS) shadow[i].ls_ctrl <= pb[1];
          end
          // Mask bits above NUM_CHANNELS-1 are never visited.
          if (cmd_func == FN_COMMIT && cmd_data[i]) begin
            active[i]     <= shadow[i];
            cfg_update[i] <= 1'b1;
          end
        end
        for (int k = 0; k < RESP_MAX; k++) resp_buf[k] <= rsp[k];
        resp_len <= rsp_len;
        resp_idx <= '0;
      end

      if (state == S_RESP && tx_ready) resp_idx <= resp_idx + 4'd1;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_bus
    assign hs_ctrl_sta_bus[8*g +: 8]           = active[g].ctrl;
    assign duty_num_bus[8*g +: 8]              = active[g].duty;
    assign pulse_dessert_bus[16*g +: 16]       = active[g].dessert;
    assign pulse_num_bus[8*g +: 8]             = active[g].num;
    assign pat_bus[PAT_WIDTH*g +: PAT_WIDTH]   = active[g].pat;
    assign ls_ctrl_sta_bus[8*g +: 8]           = active[g].ls_ctrl;
    assign pwm_en[g]                           = active[g].ctrl[0];
  end

endmodule

// File: tb/tb_uart_reg_bank_v2.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bank_v2
//
// Directed bench for uart_reg_bank_v2. Instance dut_a uses the defaults
// (4 channels, 32-bit pattern); dut_b uses 8 channels with a 16-bit pattern.
// Both share clock, reset, command and tx_ready; each has its own pack_done.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_reg_bank_v2;

  logic         clk_50M = 1'b0;
  logic         rst;
  logic [7:0]   func_reg;
  logic [87:0]  pkt_data;
  logic         pack_done_a;
  logic         pack_done_b;
  logic         tx_ready;

  logic [31:0]  hs_a, duty_a, num_a, ls_a;
  logic [63:0]  des_a;
  logic [127:0] pat_a;
  logic [3:0]   pwm_a, cfg_a;
  logic [7:0]   txd_a, err_a;
  logic         txv_a, busy_a;

  logic [63:0]  hs_b, duty_b, num_b, ls_b;
  logic [127:0] des_b;
  logic [127:0] pat_b;
  logic [7:0]   pwm_b, cfg_b;
  logic [7:0]   txd_b, err_b;
  logic         txv_b, busy_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx  [16];
  int         rx_n;
  logic [7:0] exp_b [16];
  int         exp_n;

  always #10 clk_50M = ~clk_50M;

  uart_reg_bank_v2 dut_a (
    .clk_50M(clk_50M), .rst(rst), .func_reg(func_reg), .pkt_data(pkt_data),
    .pack_done(pack_done_a), .hs_ctrl_sta_bus(hs_a), .duty_num_bus(duty_a),
    .pulse_dessert_bus(des_a), .pulse_num_bus(num_a), .pat_bus(pat_a),
    .ls_ctrl_sta_bus(ls_a), .pwm_en(pwm_a), .cfg_update(cfg_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready), .busy(busy_a),
    .err_cnt(err_a)
  );

  uart_reg_bank_v2 #(.NUM_CHANNELS(8), .PAT_WIDTH(16)) dut_b (
    .clk_50M(clk_50M), .rst(rst), .func_reg(func_reg), .pkt_data(pkt_data),
    .pack_done(pack_done_b), .hs_ctrl_sta_bus(hs_b), .duty_num_bus(duty_b),
    .pulse_dessert_bus(des_b), .pulse_num_bus(num_b), .pat_bus(pat_b),
    .ls_ctrl_sta_bus(ls_b), .pwm_en(pwm_b), .cfg_update(cfg_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready), .busy(busy_b),
    .err_cnt(err_b)
  );

  function automatic logic [87:0] pkt(input logic [7:0] b0, b1, b2, b3, b4,
                                      b5, b6, b7, b8, b9);
    return {8'h00, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  // Expected short response, written out by hand.
  task automatic set_exp4(input logic [7:0] e0, e1, e2, e3);
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    exp_n = 4;
  endtask

  // Expected 14-byte read-back; the checksum is folded here by the bench.
  task automatic set_exp_rb(input logic [7:0] ch, ctrl, duty, dh, dl, num,
                            p3, p2, p1, p0, ls);
    logic [7:0] x;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h04; exp_b[2] = ch;  exp_b[3] = ctrl;
    exp_b[4] = duty;  exp_b[5] = dh;    exp_b[6] = dl;  exp_b[7] = num;
    exp_b[8] = p3;    exp_b[9] = p2;    exp_b[10] = p1; exp_b[11] = p0;
    exp_b[12] = ls;
    x = 8'h00;
    for (int k = 0; k < 13; k++) x = x ^ exp_b[k];
    exp_b[13] = x;
    exp_n = 14;
  endtask

  // Index of the first differing byte, -2 on length difference, -1 if equal.
  function automatic int first_diff();
    if (rx_n != exp_n) return -2;
    for (int k = 0; k < exp_n; k++) if (rx[k] !== exp_b[k]) return k;
    return -1;
  endfunction

  task automatic check_resp(input string name);
    int d;
    d = first_diff();
    checks++;
    if (d == -2) begin
      failures++;
      $display("FAIL %s: got %0d bytes, required %0d", name, rx_n, exp_n);
    end else if (d >= 0) begin
      failures++;
      $display("FAIL %s: byte %0d got %02h, required %02h", name, d, rx[d], exp_b[d]);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 of the first cycle in RESP.
  task automatic send(input bit sel, input logic [7:0] f, input logic [87:0] d);
    func_reg = f;
    pkt_data = d;
    if (sel) pack_done_b = 1'b1; else pack_done_a = 1'b1;
    @(posedge clk_50M); #1;
    pack_done_a = 1'b0;
    pack_done_b = 1'b0;
    @(posedge clk_50M); #1;
  endtask

  // Drains one response, checking hold-under-backpressure and the idle state
  // that must follow the last byte.
  task automatic collect(input bit sel, input bit bp);
    logic [7:0] held, d;
    logic       v;
    bit         holding;
    int         cyc;
    rx_n = 0; holding = 0; cyc = 0; held = '0;
    tx_ready = !bp;
    forever begin
      v = sel ? txv_b : txv_a;
      d = sel ? txd_b : txd_a;
      if (!v) break;
      if (holding) begin
        checks++;
        if (d !== held) begin
          failures++;
          $display("FAIL hold_stable: byte %0d got %02h, required %02h", rx_n, d, held);
        end
      end
      if (tx_ready) begin
        if (rx_n < 16) rx[rx_n] = d;
        rx_n++;
        holding = 0;
      end else begin
        held = d;
        holding = 1;
      end
      if (cyc >= 100) begin
        checks++; failures++;
        $display("FAIL resp_timeout: got %0d bytes, required end of stream", rx_n);
        break;
      end
      @(posedge clk_50M); #1;
      cyc++;
      if (bp) tx_ready = !tx_ready;
    end
    checks++;
    if ((sel ? busy_b : busy_a) !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_resp: got %b, required 0", sel ? busy_b : busy_a);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    rst = 1'b0;
    checks++;
    if ({hs_a, duty_a, num_a, ls_a, des_a, pat_a} !== '0) begin
      failures++;
      $display("FAIL reset_buses: got nonzero active bus, required 0");
    end
    checks++;
    if ({txv_a, busy_a, pwm_a, cfg_a, txd_a, err_a} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b %b %h %h %h %h, required all 0",
               txv_a, busy_a, pwm_a, cfg_a, txd_a, err_a);
    end
  endtask

  task automatic test_write_commit();
    send(0, 8'h01, pkt(8'h01, 8'h01, 8'h10, 8'h00, 8'h32, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF));
    checks++;
    if (txv_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL latency: tx_valid=%b busy=%b, required 1 1", txv_a, busy_a);
    end
    checks++;
    if (hs_a !== '0 || pat_a !== '0 || cfg_a !== '0) begin
      failures++;
      $display("FAIL shadow_leak: hs=%h cfg=%h, required 0", hs_a, cfg_a);
    end
    collect(0, 0);
    set_exp4(8'hA5, 8'h01, 8'h00, 8'hA4);
    check_resp("resp_write");

    send(0, 8'h03, pkt(8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (cfg_a !== 4'b0010) begin
      failures++; $display("FAIL cfg_update: got %b, required 0010", cfg_a);
    end
    checks++;
    if (pat_a[63:32] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL pat_ch1: got %h, required deadbeef", pat_a[63:32]);
    end
    checks++;
    if (duty_a !== 32'h0000_1000 || des_a !== 64'h0000_0000_0032_0000 || num_a !== 32'h0000_0500) begin
      failures++;
      $display("FAIL active_fields: duty=%h dessert=%h num=%h, required 00001000 0000000000320000 00000500",
               duty_a, des_a, num_a);
    end
    checks++;
    if (pwm_a !== 4'b0010 || hs_a !== 32'h0000_0100) begin
      failures++; $display("FAIL pwm_en: got %b hs=%h, required 0010 00000100", pwm_a, hs_a);
    end
    @(posedge clk_50M); #1;
    checks++;
    if (cfg_a !== 4'b0000) begin
      failures++; $display("FAIL cfg_pulse_width: got %b, required 0000", cfg_a);
    end
    collect(0, 0);
    set_exp4(8'hA5, 8'h03, 8'h00, 8'hA6);
    check_resp("resp_commit");
  endtask

  task automatic test_shadow_isolation();
    send(0, 8'h01, pkt(8'h00, 8'h03, 8'h44, 8'h55, 8'h66, 8'h77, 8'h11, 8'h22, 8'h33, 8'h44));
    collect(0, 0);
    set_exp4(8'hA5, 8'h01, 8'h00, 8'hA4);
    check_resp("resp_write_ch0");
    send(0, 8'h02, pkt(8'h01, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0));
    collect(0, 0);
    set_exp4(8'hA5, 8'h02, 8'h00, 8'hA7);
    check_resp("resp_write_ls");
    checks++;
    if (hs_a !== 32'h0000_0100 || pat_a[31:0] !== '0 || ls_a !== '0) begin
      failures++;
      $display("FAIL shadow_isolation: hs=%h pat0=%h ls=%h, required 00000100 0 0",
               hs_a, pat_a[31:0], ls_a);
    end
    send(0, 8'h04, pkt(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    collect(0, 0);
    set_exp_rb(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_resp("readback_ch0_zero");
  endtask

  task automatic test_readback_backpressure();
    send(0, 8'h04, pkt(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    collect(0, 1);
    set_exp_rb(8'h01, 8'h01, 8'h10, 8'h00, 8'h32, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00);
    checks++;
    if (exp_b[13] !== 8'hA4) begin
      failures++; $display("FAIL readback_xor_model: got %02h, required a4", exp_b[13]);
    end
    check_resp("readback_ch1_bp");
  endtask

  task automatic test_errors();
    send(0, 8'h01, pkt(8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
    checks++;
    if (err_a !== 8'd1) begin
      failures++; $display("FAIL err_bad_ch: got %0d, required 1", err_a);
    end
    collect(0, 0);
    set_exp4(8'hA5, 8'h01, 8'h01, 8'hA5);
    check_resp("resp_bad_ch");

    send(0, 8'h7F, pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (err_a !== 8'd2) begin
      failures++; $display("FAIL err_bad_func: got %0d, required 2", err_a);
    end
    collect(0, 0);
    set_exp4(8'hA5, 8'h7F, 8'h02, 8'hD8);
    check_resp("resp_bad_func");

    // Mask bits above the channel count are ignored, so this is a no-op.
    send(0, 8'h03, pkt(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (cfg_a !== 4'b0000 || hs_a !== 32'h0000_0100 || err_a !== 8'd2) begin
      failures++;
      $display("FAIL commit_high_mask: cfg=%b hs=%h err=%0d, required 0000 00000100 2",
               cfg_a, hs_a, err_a);
    end
    collect(0, 0);
    set_exp4(8'hA5, 8'h03, 8'h00, 8'hA6);
    check_resp("resp_commit_noop");

    send(0, 8'h04, pkt(8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    collect(0, 0);
    set_exp4(8'hA5, 8'h04, 8'h01, 8'hA0);
    check_resp("resp_read_bad_ch");
    checks++;
    if (err_a !== 8'd3) begin
      failures++; $display("FAIL err_read_bad_ch: got %0d, required 3", err_a);
    end
  endtask

  task automatic test_overrun();
    send(0, 8'h04, pkt(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // A commit of ch0 arriving now must be dropped without touching ch0.
    func_reg = 8'h03;
    pkt_data = pkt(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pack_done_a = 1'b1;
    @(posedge clk_50M); #1;
    pack_done_a = 1'b0;
    @(posedge clk_50M); #1;
    checks++;
    if (err_a !== 8'd4 || hs_a[7:0] !== 8'h00 || cfg_a !== 4'b0000) begin
      failures++;
      $display("FAIL overrun_drop: err=%0d hs0=%h cfg=%b, required 4 00 0000", err_a, hs_a[7:0], cfg_a);
    end
    collect(0, 0);
    set_exp_rb(8'h01, 8'h01, 8'h10, 8'h00, 8'h32, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00);
    check_resp("readback_after_overrun");
  endtask

  task automatic test_err_saturate();
    send(0, 8'h7F, pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pack_done_a = 1'b1;
    repeat (300) @(posedge clk_50M);
    #1;
    pack_done_a = 1'b0;
    checks++;
    if (err_a !== 8'hFF) begin
      failures++; $display("FAIL err_saturate: got %02h, required ff", err_a);
    end
    collect(0, 0);
    set_exp4(8'hA5, 8'h7F, 8'h02, 8'hD8);
    check_resp("resp_after_saturate");
    checks++;
    if (err_a !== 8'hFF) begin
      failures++; $display("FAIL err_hold_ff: got %02h, required ff", err_a);
    end
  endtask

  task automatic test_reset_mid_response();
    send(0, 8'h04, pkt(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tx_ready = 1'b1;
    @(posedge clk_50M); #1;
    tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk_50M); #1;
    rst = 1'b0;
    checks++;
    if (txv_a !== 1'b0 || busy_a !== 1'b0 || err_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_abort: tx_valid=%b busy=%b err=%02h, required 0 0 00", txv_a, busy_a, err_a);
    end
    checks++;
    if ({hs_a, duty_a, num_a, ls_a, des_a, pat_a, pwm_a} !== '0) begin
      failures++; $display("FAIL reset_abort_buses: got nonzero active bus, required 0");
    end
    // Back-to-back after reset: active bank must read back as zero.
    send(0, 8'h04, pkt(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    collect(0, 0);
    set_exp_rb(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_resp("readback_after_reset");
  endtask

  task automatic test_param_sweep();
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c = 8'(i);
      send(1, 8'h01, pkt(c, 8'h10 + c, 8'h20 + c, 8'h30 + c, 8'h40 + c, 8'h50 + c,
                         8'hAA, 8'hBB, 8'hC0 + c, 8'hD0 + c));
      collect(1, 0);
      set_exp4(8'hA5, 8'h01, 8'h00, 8'hA4);
      check_resp("sweep_write");
    end
    checks++;
    if (pat_b !== '0 || hs_b !== '0) begin
      failures++; $display("FAIL sweep_shadow: got nonzero active bus, required 0");
    end
    send(1, 8'h03, pkt(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (cfg_b !== 8'hFF || pwm_b !== 8'b1010_1010) begin
      failures++; $display("FAIL sweep_commit: cfg=%b pwm=%b, required 11111111 10101010", cfg_b, pwm_b);
    end
    for (int i = 0; i < 8; i++) begin
      c = 8'(i);
      checks++;
      if (pat_b[16*i +: 16] !== {8'hC0 + c, 8'hD0 + c} || hs_b[8*i +: 8] !== 8'h10 + c) begin
        failures++;
        $display("FAIL sweep_ch%0d: pat=%h hs=%h, required %h %h", i, pat_b[16*i +: 16],
                 hs_b[8*i +: 8], {8'hC0 + c, 8'hD0 + c}, 8'h10 + c);
      end
    end
    collect(1, 0);
    set_exp4(8'hA5, 8'h03, 8'h00, 8'hA6);
    check_resp("sweep_resp_commit");
    send(1, 8'h04, pkt(8'h07, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    collect(1, 0);
    set_exp_rb(8'h07, 8'h17, 8'h27, 8'h37, 8'h47, 8'h57, 8'h00, 8'h00, 8'hC7, 8'hD7, 8'h00);
    check_resp("sweep_readback_ch7");
  endtask

  initial begin
    rst = 1'b1;
    func_reg = '0;
    pkt_data = '0;
    pack_done_a = 1'b0;
    pack_done_b = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk_50M); #1;
    test_reset();
    test_write_commit();
    test_shadow_isolation();
    test_readback_backpressure();
    test_errors();
    test_overrun();
    test_err_saturate();
    test_reset_mid_response();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
